// File: rtl/tumble_pkg.sv
// Shared types for the Turing Tumble ball dispenser: FSM states,
// run-result codes and the left/right side encoding.
package tumble_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RELEASE   = 2'd1,
    IN_FLIGHT = 2'd2,
    DONE      = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ST_NONE      = 3'd0,
    ST_INTERCEPT = 3'd1,
    ST_EMPTY     = 3'd2,
    ST_TIMEOUT   = 3'd3,
    ST_COLLISION = 3'd4
  } status_t;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/ball_reservoir.sv
// One colour's ball reservoir: a saturating down-counter that reloads to
// its initial fill and never wraps below zero.
module ball_reservoir #(
  parameter int INIT = 8,
  parameter int W    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         empty
);

  assign empty = (count == '0);

  // Reload has priority; a decrement on an empty reservoir is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= W'(INIT);
    end else if (load) begin
      count <= W'(INIT);
    end else if (dec && !empty) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/ball_dispenser.sv
// Ball dispenser sequencer: releases blue/red balls into the board, waits
// for a lever (or interceptor / timeout) and picks the next release side.
module ball_dispenser
  import tumble_pkg::*;
#(
  parameter int BALLS_BLUE = 8,
  parameter int BALLS_RED  = 8,
  parameter int CNT_W      = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             first_sel,
  input  logic             clear,
  input  logic             lever_left,
  input  logic             lever_right,
  input  logic             intercepted,
  output logic             o_left,
  output logic             o_right,
  output logic             busy,
  output logic             done,
  output logic [2:0]       status,
  output logic [CNT_W-1:0] blue_left,
  output logic [CNT_W-1:0] red_left
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  status_t          status_q, status_d;
  logic             side_q, side_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             left_d, right_d;
  logic             dec_blue, dec_red, load;
  logic             blue_empty, red_empty, sel_empty;

  ball_reservoir #(.INIT(BALLS_BLUE), .W(CNT_W)) u_blue (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .dec   (dec_blue),
    .count (blue_left),
    .empty (blue_empty)
  );

  ball_reservoir #(.INIT(BALLS_RED), .W(CNT_W)) u_red (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .dec   (dec_red),
    .count (red_left),
    .empty (red_empty)
  );

  assign sel_empty = (side_q == RIGHT) ? red_empty : blue_empty;
  assign busy      = (state_q == RELEASE) || (state_q == IN_FLIGHT);
  assign done      = (state_q == DONE);
  assign status    = status_q;

  // State, side, result, flight timer and the one-cycle release pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      status_q <= ST_NONE;
      side_q   <= LEFT;
      timer_q  <= '0;
      o_left   <= 1'b0;
      o_right  <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      side_q   <= side_d;
      timer_q  <= timer_d;
      o_left   <= left_d;
      o_right  <= right_d;
    end
  end

  // Next-state logic; board inputs only matter while a ball is in flight.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    side_d   = side_q;
    timer_d  = timer_q;
    left_d   = 1'b0;
    right_d  = 1'b0;
    dec_blue = 1'b0;
    dec_red  = 1'b0;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          side_d   = first_sel;
          status_d = ST_NONE;
          state_d  = RELEASE;
        end
      end
      RELEASE: begin
        if (sel_empty) begin
          status_d = ST_EMPTY;
          state_d  = DONE;
        end else begin
          if (side_q == RIGHT) begin
            dec_red = 1'b1;
            right_d = 1'b1;
          end else begin
            dec_blue = 1'b1;
            left_d   = 1'b1;
          end
          timer_d = '0;
          state_d = IN_FLIGHT;
        end
      end
      IN_FLIGHT: begin
        if (intercepted) begin
          status_d = ST_INTERCEPT;
          state_d  = DONE;
        end else if (lever_left && lever_right) begin
          status_d = ST_COLLISION;
          state_d  = DONE;
        end else if (lever_left) begin
          side_d  = LEFT;
          state_d = RELEASE;
        end else if (lever_right) begin
          side_d  = RIGHT;
          state_d = RELEASE;
        end else if (timer_q == TMR_LAST) begin
          status_d = ST_TIMEOUT;
          state_d  = DONE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      DONE: begin
        if (clear) begin
          load     = 1'b1;
          status_d = ST_NONE;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ball_dispenser.sv
// Self-checking bench for ball_dispenser: directed scenarios plus random
// runs compared against a ball-count / run-result model.
module tb_ball_dispenser;
  localparam int NB = 8;
  localparam int NR = 8;
  localparam int TO = 16;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, first_sel = 1'b0, clear = 1'b0;
  logic lever_left = 1'b0, lever_right = 1'b0, intercepted = 1'b0;
  logic o_left, o_right, busy, done;
  logic [2:0] status;
  logic [3:0] blue_left, red_left;

  int n_cmp = 0, n_fail = 0;
  int pl = 0, pr = 0;

  ball_dispenser #(.BALLS_BLUE(NB), .BALLS_RED(NR), .CNT_W(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_sel(first_sel), .clear(clear),
    .lever_left(lever_left), .lever_right(lever_right), .intercepted(intercepted),
    .o_left(o_left), .o_right(o_right), .busy(busy), .done(done), .status(status),
    .blue_left(blue_left), .red_left(red_left)
  );

  always #5 clk = ~clk;

  // pulse counters, sampled mid-cycle
  always @(negedge clk) if (rst_n) begin
    if (o_left) pl++;
    if (o_right) pr++;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic launch(input logic s);
    first_sel = s; start = 1'b1; tick(); start = 1'b0; first_sel = 1'b0;
  endtask

  task automatic do_clear;
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    n_cmp++; if (o_left !== 1'b0 || o_right !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %b%b want 00", o_left, o_right); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    n_cmp++; if (status !== 3'd0) begin n_fail++; $display("FAIL reset_status: got %0d want 0", status); end
    n_cmp++; if (blue_left !== 4'(NB) || red_left !== 4'(NR)) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want %0d/%0d", blue_left, red_left, NB, NR); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_idle_ignore;
    int p0, q0;
    p0 = pl; q0 = pr;
    lever_left = 1'b1; lever_right = 1'b1; intercepted = 1'b1; clear = 1'b1;
    repeat (3) tick();
    lever_left = 1'b0; lever_right = 1'b0; intercepted = 1'b0; clear = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || status !== 3'd0) begin n_fail++; $display("FAIL idle_ignore_state: got busy=%b done=%b status=%0d want 0 0 0", busy, done, status); end
    n_cmp++; if (pl != p0 || pr != q0) begin n_fail++; $display("FAIL idle_ignore_pulses: got %0d/%0d want %0d/%0d", pl, pr, p0, q0); end
  endtask

  task automatic test_lever_left;
    int p0, q0;
    p0 = pl; q0 = pr;
    launch(1'b0);
    n_cmp++; if (busy !== 1'b1 || o_left !== 1'b0) begin n_fail++; $display("FAIL ll_release: got busy=%b o_left=%b want 1 0", busy, o_left); end
    tick();
    n_cmp++; if (o_left !== 1'b1 || blue_left !== 4'(NB-1)) begin n_fail++; $display("FAIL ll_first_pulse: got o_left=%b blue=%0d want 1 %0d", o_left, blue_left, NB-1); end
    for (int k = 0; k < 3; k++) begin
      repeat (5) tick();
      lever_left = 1'b1; tick(); lever_left = 1'b0;
      n_cmp++; if (o_left !== 1'b0) begin n_fail++; $display("FAIL ll_gap%0d: got o_left=%b want 0", k, o_left); end
      tick();
      n_cmp++; if (o_left !== 1'b1) begin n_fail++; $display("FAIL ll_pulse%0d: got o_left=%b want 1", k, o_left); end
    end
    n_cmp++; if (blue_left !== 4'd4 || red_left !== 4'(NR)) begin n_fail++; $display("FAIL ll_counts: got %0d/%0d want 4/%0d", blue_left, red_left, NR); end
    for (int n = 0; n < 40 && !done; n++) tick();
    n_cmp++; if (done !== 1'b1 || status !== 3'd3) begin n_fail++; $display("FAIL ll_end: got done=%b status=%0d want 1 3", done, status); end
    n_cmp++; if (pl - p0 != 4 || pr != q0) begin n_fail++; $display("FAIL ll_pulse_count: got %0d/%0d want 4/0", pl - p0, pr - q0); end
    do_clear();
    n_cmp++; if (done !== 1'b0 || blue_left !== 4'(NB) || status !== 3'd0) begin n_fail++; $display("FAIL ll_clear: got done=%b blue=%0d status=%0d want 0 %0d 0", done, blue_left, status, NB); end
  endtask

  task automatic test_empty;
    int got;
    got = 0;
    launch(1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_left !== 1'b1) break;
      got++;
      repeat ($urandom_range(0, 4)) tick();
      lever_left = 1'b1; tick(); lever_left = 1'b0;
    end
    n_cmp++; if (got != NB) begin n_fail++; $display("FAIL empty_pulses: got %0d want %0d", got, NB); end
    n_cmp++; if (done !== 1'b1 || status !== 3'd2 || busy !== 1'b0) begin n_fail++; $display("FAIL empty_state: got done=%b status=%0d busy=%b want 1 2 0", done, status, busy); end
    n_cmp++; if (blue_left !== 4'd0 || red_left !== 4'(NR) || o_right !== 1'b0) begin n_fail++; $display("FAIL empty_counts: got %0d/%0d o_right=%b want 0/%0d 0", blue_left, red_left, o_right, NR); end
    do_clear();
    n_cmp++; if (blue_left !== 4'(NB) || red_left !== 4'(NR) || done !== 1'b0 || busy !== 1'b0 || status !== 3'd0) begin n_fail++; $display("FAIL empty_clear: got %0d/%0d done=%b busy=%b status=%0d", blue_left, red_left, done, busy, status); end
  endtask

  task automatic test_intercept;
    int q0;
    launch(1'b1);
    tick();
    n_cmp++; if (o_right !== 1'b1 || red_left !== 4'(NR-1)) begin n_fail++; $display("FAIL ic_pulse: got o_right=%b red=%0d want 1 %0d", o_right, red_left, NR-1); end
    repeat ($urandom_range(0, 5)) tick();
    intercepted = 1'b1; lever_right = 1'b1; tick(); intercepted = 1'b0; lever_right = 1'b0;
    q0 = pr;
    n_cmp++; if (done !== 1'b1 || status !== 3'd1 || o_right !== 1'b0) begin n_fail++; $display("FAIL ic_state: got done=%b status=%0d o_right=%b want 1 1 0", done, status, o_right); end
    repeat (6) tick();
    n_cmp++; if (pr != q0 || red_left !== 4'(NR-1) || status !== 3'd1) begin n_fail++; $display("FAIL ic_after: got extra=%0d red=%0d status=%0d want 0 %0d 1", pr - q0, red_left, status, NR-1); end
    do_clear();
  endtask

  task automatic test_timeout;
    int n;
    launch(1'b0);
    tick();
    n_cmp++; if (o_left !== 1'b1) begin n_fail++; $display("FAIL to_pulse: got %b want 1", o_left); end
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    n_cmp++; if (n != TO) begin n_fail++; $display("FAIL to_latency: got %0d want %0d", n, TO); end
    n_cmp++; if (status !== 3'd3 || blue_left !== 4'(NB-1)) begin n_fail++; $display("FAIL to_status: got status=%0d blue=%0d want 3 %0d", status, blue_left, NB-1); end
    do_clear();
  endtask

  task automatic test_collision;
    logic s;
    int p0, q0;
    s = 1'($urandom % 2);
    launch(s);
    tick();
    repeat ($urandom_range(0, 5)) tick();
    lever_left = 1'b1; lever_right = 1'b1; tick(); lever_left = 1'b0; lever_right = 1'b0;
    n_cmp++; if (done !== 1'b1 || status !== 3'd4) begin n_fail++; $display("FAIL col_state: got done=%b status=%0d want 1 4", done, status); end
    p0 = pl; q0 = pr;
    first_sel = ~s; start = 1'b1; tick(); start = 1'b0; first_sel = 1'b0;
    repeat (4) tick();
    n_cmp++; if (done !== 1'b1 || status !== 3'd4 || busy !== 1'b0) begin n_fail++; $display("FAIL col_start_ignored: got done=%b status=%0d busy=%b want 1 4 0", done, status, busy); end
    n_cmp++; if (pl != p0 || pr != q0) begin n_fail++; $display("FAIL col_no_pulse: got %0d/%0d extra want 0/0", pl - p0, pr - q0); end
    n_cmp++; if (blue_left !== 4'(s ? NB : NB-1) || red_left !== 4'(s ? NR-1 : NR)) begin n_fail++; $display("FAIL col_counts: got %0d/%0d", blue_left, red_left); end
    do_clear();
  endtask

  task automatic test_random_runs;
    int mb, mr, act, d, n;
    logic s;
    for (int run = 0; run < 10; run++) begin
      mb = NB; mr = NR;
      s = 1'($urandom % 2);
      launch(s);
      for (int it = 0; it < 40; it++) begin
        tick();
        if ((s ? mr : mb) == 0) begin
          n_cmp++; if (done !== 1'b1 || status !== 3'd2 || o_left !== 1'b0 || o_right !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_empty: got done=%b status=%0d pulses=%b%b", run, done, status, o_left, o_right); end
          break;
        end
        if (s) mr--; else mb--;
        n_cmp++; if (o_left !== ~s || o_right !== s) begin n_fail++; $display("FAIL rnd%0d_pulse: got %b%b side=%b", run, o_left, o_right, s); end
        n_cmp++; if (blue_left !== 4'(mb) || red_left !== 4'(mr)) begin n_fail++; $display("FAIL rnd%0d_count: got %0d/%0d want %0d/%0d", run, blue_left, red_left, mb, mr); end
        act = $urandom_range(0, 9);
        d = $urandom_range(0, 6);
        repeat (d) tick();
        if (act == 0) begin
          intercepted = 1'b1; lever_left = 1'($urandom % 2); tick(); intercepted = 1'b0; lever_left = 1'b0;
          n_cmp++; if (done !== 1'b1 || status !== 3'd1) begin n_fail++; $display("FAIL rnd%0d_intercept: got done=%b status=%0d", run, done, status); end
          break;
        end else if (act == 1) begin
          lever_left = 1'b1; lever_right = 1'b1; tick(); lever_left = 1'b0; lever_right = 1'b0;
          n_cmp++; if (done !== 1'b1 || status !== 3'd4) begin n_fail++; $display("FAIL rnd%0d_collision: got done=%b status=%0d", run, done, status); end
          break;
        end else if (act == 2) begin
          n = d;
          while (!done && n < 40) begin tick(); n++; end
          n_cmp++; if (n != TO || status !== 3'd3) begin n_fail++; $display("FAIL rnd%0d_timeout: got %0d cycles status=%0d want %0d 3", run, n, status, TO); end
          break;
        end else begin
          s = 1'($urandom % 2);
          if (s) lever_right = 1'b1; else lever_left = 1'b1;
          tick();
          lever_left = 1'b0; lever_right = 1'b0;
        end
      end
      n_cmp++; if (blue_left !== 4'(mb) || red_left !== 4'(mr) || done !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_final: got %0d/%0d done=%b want %0d/%0d 1", run, blue_left, red_left, done, mb, mr); end
      do_clear();
    end
  endtask

  task automatic test_reset_mid_pulse;
    launch(1'b1);
    tick();
    n_cmp++; if (o_right !== 1'b1) begin n_fail++; $display("FAIL rst_pre_pulse: got %b want 1", o_right); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (o_right !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_drop: got o_right=%b busy=%b want 0 0", o_right, busy); end
    n_cmp++; if (red_left !== 4'(NR)) begin n_fail++; $display("FAIL rst_async_count: got %0d want %0d", red_left, NR); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    n_cmp++; if (status !== 3'd0 || done !== 1'b0 || busy !== 1'b0 || blue_left !== 4'(NB) || red_left !== 4'(NR)) begin n_fail++; $display("FAIL rst_after: got status=%0d done=%b busy=%b counts=%0d/%0d", status, done, busy, blue_left, red_left); end
    launch(1'b0);
    tick();
    n_cmp++; if (o_left !== 1'b1 || blue_left !== 4'(NB-1)) begin n_fail++; $display("FAIL rst_restart: got o_left=%b blue=%0d want 1 %0d", o_left, blue_left, NB-1); end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_lever_left();
    test_empty();
    test_intercept();
    test_timeout();
    test_collision();
    test_random_runs();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ball_dispenser.md
# ball_dispenser

Clocked sequencer that feeds a Turing Tumble board built from ramp, crossover, bit and interceptor cells. It holds the blue (left) and red (right) ball reservoirs and pulses a ball into the board's top-left or top-right input. It then waits for the ball to reach the bottom left or bottom right lever, and uses that lever to choose the next release. A run ends on interceptor capture, an empty reservoir, a timeout, or a lever collision.

## Interface
- `BALLS_BLUE`, 8: initial blue ball count.
- `BALLS_RED`, 8: initial red ball count.
- `CNT_W`, 4: reservoir counter width; must hold both counts.
- `TIMEOUT`, 64: maximum cycles allowed from a release pulse to a lever event; at least 2.
- `clk`  in  1  board clock; one clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse that begins a run; honoured only in IDLE.
- `first_sel`  in  1  side of the first ball, sampled with `start`; 0 = blue/left, 1 = red/right.
- `clear`  in  1  pulse that refills both reservoirs and returns to IDLE; honoured only in DONE.
- `lever_left`  in  1  ball reached the bottom left lever.
- `lever_right`  in  1  ball reached the bottom right lever.
- `intercepted`  in  1  level; OR of all interceptor `occupied` outputs.
- `o_left`  out  1  one-cycle registered pulse that drops a blue ball.
- `o_right`  out  1  one-cycle registered pulse that drops a red ball.
- `busy`  out  1  high in RELEASE and IN_FLIGHT.
- `done`  out  1  high in DONE.
- `status`  out  3  run result: 0 NONE, 1 INTERCEPT, 2 EMPTY, 3 TIMEOUT, 4 COLLISION.
- `blue_left`  out  CNT_W  blue balls remaining.
- `red_left`  out  CNT_W  red balls remaining.

## Operation
- States: IDLE, RELEASE, IN_FLIGHT, DONE. `side` register holds the side of the next release.
- Reset values: state IDLE, `side` 0, `o_left`/`o_right` 0, `status` 0, `blue_left` = BALLS_BLUE, `red_left` = BALLS_RED.
- IDLE: on `start`, `side` ← `first_sel`, `status` ← NONE, go to RELEASE.
- RELEASE (exactly one cycle):
  - Selected reservoir 0: `status` ← EMPTY, go to DONE; no pulse is issued.
  - Otherwise: decrement that reservoir, assert the matching `o_*` on the next cycle, clear the timer, go to IN_FLIGHT.
- IN_FLIGHT priority, highest first:
  - `intercepted`: INTERCEPT, go to DONE.
  - `lever_left` and `lever_right` together: COLLISION, go to DONE.
  - `lever_left`: `side` ← 0, go to RELEASE.
  - `lever_right`: `side` ← 1, go to RELEASE.
  - Timer equals TIMEOUT−1: TIMEOUT, go to DONE.
- Lever and `intercepted` inputs are ignored outside IN_FLIGHT.
- DONE: `status` holds its value. `clear` reloads both reservoirs, sets `status` ← NONE, and goes to IDLE. `start` is ignored.
- A new run after reaching IDLE does not refill the reservoirs; only `clear` and reset do.
- Counters never wrap. Decrement happens only when the count is nonzero.

## Timing
- `start` sampled at edge E: RELEASE runs E→E+1, and `o_*` is high from E+1 to E+2 (latency 2 edges).
- Lever sampled at edge E in IN_FLIGHT: next `o_*` is high from E+1 to E+2.
- Count decrements are visible the same cycle `o_*` is high.
- The timer counts cycles in IN_FLIGHT, with the pulse cycle counting as 0. No event in TIMEOUT cycles gives `done` at pulse+TIMEOUT.
- `done` and `status` update together, one edge after the terminating event is sampled.
- `rst_n` low at any time immediately forces all reset values, including mid-flight with a pulse in progress. An in-progress `o_*` drops asynchronously.
- Inputs are synchronous to `clk`; the block does no synchronisation.

## Structure
- Package `tumble_pkg`: state enum (IDLE, RELEASE, IN_FLIGHT, DONE), `status` codes, side constants LEFT=0 and RIGHT=1.
- Sub-module `ball_reservoir` (parameters INIT and W; ports load, dec, count, empty), instantiated once per colour.
- Top level holds the FSM, the timer (width $clog2(TIMEOUT)), and the pulse registers.

## Test plan
- BALLS_BLUE=8: `start`, `first_sel`=0; `lever_left` 5 cycles after each pulse, 3 times → 4 `o_left` pulses, spaced by the lever latency; `blue_left`=4; `red_left`=8.
- BALLS_BLUE=2: `start` blue, then answer every pulse with `lever_left` → exactly 2 pulses; `status`=2; `done`=1; `blue_left`=0; then `clear` → counts 2/8, IDLE.
- `start` red; `intercepted` raised together with `lever_right` → `status`=1, no further `o_right`, `red_left`=BALLS_RED−1.
- TIMEOUT=16: `start` and no lever → `done` exactly 16 cycles after the `o_left` pulse; `status`=3.
- `lever_left` and `lever_right` asserted in the same IN_FLIGHT cycle → `status`=4, no pulse; `start` in DONE is ignored.
- `rst_n` low during the `o_right` pulse cycle → pulse drops immediately; after release, counts are at their INIT values and the block is in IDLE with `status`=0.
